// File: rtl/fp_mul_host_driver_pkg.sv
// fp_mul_pkg: driver state encoding, bus word width and the quiet-NaN returned on timeout
package fp_mul_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] FP_QNAN = 32'h7FC0_0000;
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_RES, RESP} drv_state_t;
endpackage

// File: rtl/fp_mul_host_driver_if.sv
// fp_mul_host_driver_if: req/rsp parallel port + serial multiplier bus; master = driver side, slave = environment side
interface fp_mul_host_driver_if;
  import fp_mul_pkg::*;
  logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic [WORD_W-1:0] req_a, req_b, rsp_data;
  logic inReady, inAccept, resultReady, resultAccept, busy;
  logic [WORD_W-1:0] inBus, resultBus;
  logic [15:0] op_count;
  modport master (
    input  req_valid, req_a, req_b, rsp_ready, inAccept, resultReady, resultBus,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, inReady, inBus, resultAccept, busy, op_count
  );
  modport slave (
    output req_valid, req_a, req_b, rsp_ready, inAccept, resultReady, resultBus,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, inReady, inBus, resultAccept, busy, op_count
  );
endinterface

// File: rtl/fp_mul_host_driver_timeout_ctr.sv
// mul_timeout_ctr: result-wait cycle counter; clear_i zeroes, enable_i counts, expired_o flags the last allowed cycle
module mul_timeout_ctr #(
  parameter int LIMIT = 1024,
  parameter int W = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) cnt_q <= (rst || clear_i) ? '0 : enable_i ? cnt_q + 1'b1 : cnt_q;
  assign expired_o = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/fp_mul_host_driver.sv
// fp_mul_host_driver: serialises an A/B operand pair onto the multiplier bus and returns the product (clk, rst, bus = master modport)
module fp_mul_host_driver import fp_mul_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W = 11
) (
  input logic clk,
  input logic rst,
  fp_mul_host_driver_if.master bus
);
  drv_state_t state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic to_q, to_d, stale_q, stale_d, rdy_q, rdy_d, expired;
  logic [15:0] op_count_q, op_count_d;
  logic req_fire, in_fire, res_fire;
  assign req_fire = bus.req_valid && rdy_q;
  assign in_fire = bus.inReady && bus.inAccept;
  assign res_fire = bus.resultReady && bus.resultAccept;
  mul_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES), .W(TMR_W)) u_tmr (
    .clk(clk),
    .rst(rst),
    .clear_i(state_q != WAIT_RES),
    .enable_i(state_q == WAIT_RES),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    to_d = to_q;
    stale_d = stale_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (stale_q && res_fire) stale_d = 1'b0;
        if (req_fire) begin
          a_d = bus.req_a;
          b_d = bus.req_b;
          state_d = SEND_A;
        end
      end
      SEND_A: state_d = in_fire ? SEND_B : SEND_A;
      SEND_B: state_d = in_fire ? WAIT_RES : SEND_B;
      WAIT_RES: begin
        if (res_fire) begin
          data_d = bus.resultBus;
          to_d = 1'b0;
          state_d = RESP;
        end else if (expired) begin
          data_d = FP_QNAN;
          to_d = 1'b1;
          stale_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          op_count_d = to_q ? op_count_q : op_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = state_d == IDLE && !stale_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      to_q <= 1'b0;
      stale_q <= 1'b0;
      rdy_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      to_q <= to_d;
      stale_q <= stale_d;
      rdy_q <= rdy_d;
      op_count_q <= op_count_d;
    end
  end
  assign bus.req_ready = rdy_q;
  assign bus.inReady = state_q == SEND_A || state_q == SEND_B;
  assign bus.inBus = state_q == SEND_A ? a_q : state_q == SEND_B ? b_q : '0;
  assign bus.resultAccept = state_q == WAIT_RES || (state_q == IDLE && stale_q);
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_data = data_q;
  assign bus.rsp_timeout = to_q;
  assign bus.busy = state_q != IDLE;
  assign bus.op_count = op_count_q;
endmodule

// File: tb/tb_fp_mul_host_driver.sv
// tb_fp_mul_host_driver: random and directed operations against a mock multiplier with scoreboarded responses
module tb_fp_mul_host_driver;
  import fp_mul_pkg::*;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fp_mul_host_driver_if dif();
  fp_mul_host_driver #(.TIMEOUT_CYCLES(TO), .TMR_W(4)) dut (.clk(clk), .rst(rst), .bus(dif));
  int checks = 0, errors = 0, exp_cnt = 0;
  logic [31:0] word_q[$];
  logic [32:0] rsp_q[$];
  int acc_block_cfg = 0, res_delay_cfg = 0, rsp_hold_cfg = 0;
  bit acc_rand = 0, rsp_rand = 0;
  int m_wi, m_hold, m_rwait, mon_hold;
  bit m_rpend, m_started, mon_seen;
  logic [31:0] m_w0, m_rval;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return {a[31] ^ b[31], a[30:23] + b[30:23] - 8'd127, b[22:0]};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    dif.inAccept = 0;
    dif.resultReady = 0;
    dif.resultBus = 0;
    m_wi = 0; m_hold = 0; m_rwait = 0; m_rpend = 0; m_started = 0; m_w0 = 0; m_rval = 0;
    forever begin
      step();
      if (rst) begin
        m_wi = 0; m_rpend = 0; m_started = 0; m_hold = 0;
        dif.inAccept = 0;
        dif.resultReady = 0;
        continue;
      end
      if (m_rpend && m_rwait > 0) begin
        dif.resultReady = 0;
        m_rwait--;
      end else dif.resultReady = m_rpend;
      dif.resultBus = m_rval;
      if (dif.resultReady && dif.resultAccept) m_rpend = 0;
      if (dif.inReady && !m_started) begin
        m_started = 1;
        m_hold = acc_block_cfg;
      end
      dif.inAccept = m_hold > 0 ? 1'b0 : acc_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_hold > 0) m_hold--;
      if (dif.inReady && dif.inAccept) begin
        if (word_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL inBus unexpected word %h", dif.inBus);
        end else chk("inBus word order", dif.inBus, word_q.pop_front());
        if (m_wi == 0) begin
          m_w0 = dif.inBus;
          m_wi = 1;
        end else begin
          m_wi = 0;
          m_started = 0;
          m_rpend = 1;
          m_rwait = res_delay_cfg;
          m_rval = fmul(m_w0, dif.inBus);
        end
      end
    end
  end
  initial begin
    dif.rsp_ready = 0;
    mon_seen = 0;
    mon_hold = 0;
    forever begin
      step();
      if (rst || !dif.rsp_valid) begin
        mon_seen = 0;
        dif.rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        continue;
      end
      if (!mon_seen) begin
        mon_seen = 1;
        mon_hold = rsp_hold_cfg;
      end
      dif.rsp_ready = mon_hold > 0 ? 1'b0 : rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mon_hold > 0) mon_hold--;
      if (dif.rsp_ready) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp unexpected %h", dif.rsp_data);
        end else chk("rsp {timeout,data}", {dif.rsp_timeout, dif.rsp_data}, rsp_q.pop_front());
        mon_seen = 0;
      end
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit to);
    int n = 0;
    dif.req_valid = 1;
    dif.req_a = a;
    dif.req_b = b;
    while (!dif.req_ready && n < 200) begin step(); n++; end
    chk("req accepted in time", 96'(n < 200), 96'(1));
    word_q.push_back(a);
    word_q.push_back(b);
    rsp_q.push_back(to ? {1'b1, FP_QNAN} : {1'b0, fmul(a, b)});
    step();
    dif.req_valid = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((dif.busy || rsp_q.size() != 0) && n < 500) begin step(); n++; end
    chk("op completes", 96'(n < 500), 96'(1));
  endtask
  task automatic latency(output int n);
    n = 1;
    while (!dif.rsp_valid && n < 100) begin step(); n++; end
  endtask
  task automatic chk_zero(input string name);
    chk(name, {dif.req_ready, dif.rsp_valid, dif.rsp_timeout, dif.inReady, dif.resultAccept, dif.busy,
               dif.rsp_data, dif.inBus, dif.op_count}, '0);
  endtask
  function automatic logic [31:0] rnd_pow2();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'd0};
  endfunction
  function automatic logic [31:0] rnd_norm();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction
  initial begin
    int lat;
    logic [31:0] a, b, hold_data;
    dif.req_valid = 0;
    dif.req_a = 0;
    dif.req_b = 0;
    rst = 1;
    step();
    chk_zero("outputs in reset");
    step();
    rst = 0;
    step();
    chk("req_ready after reset", dif.req_ready, 1);
    chk("op_count after reset", dif.op_count, 0);
    issue(32'h3F80_0000, 32'h4000_0000, 0);
    chk("basic inBus A", {dif.inReady, dif.inBus}, {1'b1, 32'h3F80_0000});
    step();
    chk("basic inBus B", {dif.inReady, dif.inBus}, {1'b1, 32'h4000_0000});
    step();
    chk("basic no early rsp", dif.rsp_valid, 0);
    step();
    chk("basic rsp at cycle 4", {dif.rsp_valid, dif.rsp_timeout, dif.rsp_data}, {2'b10, 32'h4000_0000});
    wait_done();
    exp_cnt++;
    chk("basic op_count", dif.op_count, 16'(exp_cnt));
    acc_block_cfg = 5;
    rsp_hold_cfg = 3;
    a = rnd_pow2();
    b = rnd_norm();
    issue(a, b, 0);
    for (int i = 0; i < 5; i++) begin
      chk("backpressure holds A", {dif.inReady, dif.inBus}, {1'b1, a});
      step();
    end
    acc_block_cfg = 0;
    latency(lat);
    hold_data = dif.rsp_data;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rsp held stable", {dif.rsp_valid, dif.req_ready, dif.rsp_data}, {2'b10, hold_data});
    end
    rsp_hold_cfg = 0;
    wait_done();
    exp_cnt++;
    chk("backpressure op_count", dif.op_count, 16'(exp_cnt));
    acc_rand = 1;
    rsp_rand = 1;
    for (int i = 0; i < 12; i++) begin
      res_delay_cfg = $urandom_range(0, 5);
      issue(rnd_pow2(), rnd_norm(), 0);
      wait_done();
      exp_cnt++;
    end
    chk("random op_count", dif.op_count, 16'(exp_cnt));
    acc_rand = 0;
    rsp_rand = 0;
    res_delay_cfg = TO - 1;
    issue(rnd_pow2(), rnd_norm(), 0);
    latency(lat);
    chk("race latency", lat, 11);
    chk("race no timeout", dif.rsp_timeout, 0);
    wait_done();
    exp_cnt++;
    res_delay_cfg = 20;
    issue(rnd_pow2(), rnd_norm(), 1);
    latency(lat);
    chk("timeout latency", lat, 11);
    chk("timeout rsp", {dif.rsp_timeout, dif.rsp_data}, {1'b1, FP_QNAN});
    wait_done();
    chk("stale blocks req", dif.req_ready, 0);
    chk("timeout op_count unchanged", dif.op_count, 16'(exp_cnt));
    lat = 0;
    while (!dif.req_ready && lat < 50) begin step(); lat++; end
    chk("stale cleared by late result", {dif.req_ready, m_rpend}, {1'b1, 1'b0});
    res_delay_cfg = 100;
    issue(rnd_pow2(), rnd_norm(), 0);
    step();
    step();
    chk("in WAIT_RES before reset", {dif.busy, dif.resultAccept, dif.inReady}, 3'b110);
    rst = 1;
    void'(rsp_q.pop_back());
    step();
    chk_zero("outputs after mid-op reset");
    chk("words consumed", word_q.size(), 0);
    step();
    rst = 0;
    exp_cnt = 0;
    step();
    chk("req_ready after mid-op reset", {dif.req_ready, dif.rsp_valid}, 2'b10);
    res_delay_cfg = 1;
    force dut.op_count_q = 16'hFFFF;
    step();
    release dut.op_count_q;
    step();
    chk("op_count preloaded", dif.op_count, 16'hFFFF);
    issue(rnd_pow2(), rnd_norm(), 0);
    wait_done();
    chk("op_count wraps", dif.op_count, 16'h0000);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
